qsys_data_mem_arbiter: RTL and testbench
========================================

Name: qsys_data_mem_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port on-chip data memory (4096 x 32, byte-enabled) between two Avalon-MM masters, e.g. CPU data master and DMA/DFT scan engine.
- Sits between the two masters and the memory's native port.
- Issues at most one access per cycle, and routes each read's return data back to its owner one cycle after issue.

Parameters:
- ADDR_W, 12, word-address width of the memory.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  freeze request. While high, no new grants are issued.
- mN_address  in  ADDR_W  requester N word address (N = 0, 1).
- mN_byteenable  in  BE_W  requester N byte lanes.
- mN_read  in  1  requester N read request.
- mN_write  in  1  requester N write request.
- mN_writedata  in  DATA_W  requester N write data.
- mN_waitrequest  out  1  high = requester N's request not accepted this cycle.
- mN_readdata  out  DATA_W  read data to requester N.
- mN_readdatavalid  out  1  mN_readdata valid this cycle.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  BE_W  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_readdata  in  DATA_W  memory q, valid 1 cycle after a read issue (registered address, unregistered output).
- proto_err  out  1  sticky. Set when any requester asserts read and write together.

Behaviour:
- Request: reqN = mN_read | mN_write.
- Grant: combinational within the cycle.
  - If hold or reset is high: no grant.
  - Else if exactly one reqN: grant that N.
  - Else if both: grant the requester that is not last_grant.
- last_grant: register, reset value 1, so m0 wins the first tie after reset. Updated to the granted index on every grant.
- Waitrequest:
  - mN_waitrequest = ~(grant to N). High when idle, high during reset and hold.
  - A transfer is accepted in the cycle its waitrequest is low. Requesters hold their signals while waitrequest is high (Avalon rule).
- Memory drive:
  - On grant, mem_* mirror the winner's address, byteenable and writedata.
  - mem_chipselect = 1; mem_write = winner's mN_write.
  - No grant: mem_chipselect = 0 and mem_write = 0. Address, byteenable and writedata are don't-care but are driven from m0 to avoid X.
- Read and write asserted together: treated as a write, read ignored, proto_err set. proto_err clears only on reset.
- Read return:
  - rd_pend (1 bit) and rd_owner register at the granting edge of a read grant.
  - Next cycle: mOwner_readdatavalid = 1 and mOwner_readdata = mem_readdata.
  - The other requester's readdatavalid stays 0.
  - Read latency is exactly 1 cycle. Back-to-back reads (any owner mix) sustain 1 per cycle.
- Writes: complete in the grant cycle, with no return.
- Hold:
  - Blocks new grants only.
  - A read granted in the cycle before hold rises still returns normally.
  - last_grant is unchanged during hold.
- Reset:
  - Synchronous. rd_pend = 0, last_grant = 1, proto_err = 0.
  - All readdatavalid = 0 and mem_chipselect = 0 in the reset cycle and in the following cycle.
  - A read granted in the cycle before reset asserts is dropped: no readdatavalid.
- Reset values:
  - mN_waitrequest = 1.
  - mN_readdatavalid = 0.
  - mN_readdata = 0. Register the mux output and zero it when not valid.
  - mem_chipselect = 0, mem_write = 0.
  - proto_err = 0.
- Readdata is 0 whenever readdatavalid is 0.

Decomposition:
- Shared package qsys_mem_pkg holds:
  - ADDR_W / DATA_W / BE_W defaults;
  - typedef req_t {address, byteenable, read, write, writedata};
  - typedef owner_t (1-bit index).
- One natural sub-module: rr_arb2. It is the 2-way round-robin grant logic with the last_grant register (inputs req[1:0], en; outputs gnt[1:0]). It is reusable for other shared slaves.

Test Plan:
- m0 write addr 0x010 data 0xDEADBEEF be 0xF, then m0 read 0x010 -> waitrequest low in both request cycles; m0_readdatavalid = 1 exactly 1 cycle after the read grant, m0_readdata = 0xDEADBEEF; m1 outputs idle.
- Both masters read every cycle for 8 cycles (m0 addr 0x100, m1 addr 0x200) -> grants alternate m0, m1, m0, …; each master sees waitrequest low every other cycle; readdatavalid alternates with the correct owner's data.
- m1 write be 0x3 data 0x0000AAAA over 0x12345678 at 0x020, then m0 read 0x020 -> m0_readdata = 0x1234AAAA.
- hold high for 3 cycles while both request, with a read granted the cycle before hold -> that read returns; no mem_chipselect during hold; after hold drops, the first grant goes to the requester not last granted.
- Reset asserted the cycle after a read grant -> no readdatavalid; all outputs at reset values; first tie after reset granted to m0.
- m0_read and m0_write both high, data 0x55 at 0x030 -> memory written with 0x55, no readdatavalid, proto_err = 1 and stays 1 until reset.

Source files
------------

// File: rtl/qsys_mem_pkg.sv
// qsys_mem_pkg: shared widths and request/owner types for the data memory arbiter
package qsys_mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  typedef logic owner_t;
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } req_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with last-grant memory, reusable for any shared slave
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last;
  always_comb begin
    gnt[0] = en & req[0] & (~req[1] | last);
    gnt[1] = en & req[1] & (~req[0] | ~last);
  end
  // last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/qsys_data_mem_arbiter.sv
// qsys_data_mem_arbiter: round-robin sharing of one single-port data memory between two Avalon-MM masters
module qsys_data_mem_arbiter #(
  parameter int ADDR_W = qsys_mem_pkg::ADDR_W,
  parameter int DATA_W = qsys_mem_pkg::DATA_W,
  parameter int BE_W   = qsys_mem_pkg::BE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              proto_err
);
  import qsys_mem_pkg::*;
  req_t       r [2];
  req_t       sel;
  logic [1:0] req, gnt;
  owner_t     win, rd_owner;
  logic       rd_pend, rst_q, en;
  assign r[0] = '{m0_address, m0_byteenable, m0_read, m0_write, m0_writedata};
  assign r[1] = '{m1_address, m1_byteenable, m1_read, m1_write, m1_writedata};
  assign req = {m1_read | m1_write, m0_read | m0_write};
  // grants stay blocked for one cycle after reset so the memory sees a clean idle cycle
  assign en = ~hold & ~reset & ~rst_q;
  rr_arb2 u_arb (.clk(clk), .rst(reset), .req(req), .en(en), .gnt(gnt));
  always_comb begin
    win = gnt[1];
    sel = r[win];
    mem_address      = sel.address;
    mem_byteenable   = sel.byteenable;
    mem_writedata    = sel.writedata;
    mem_chipselect   = |gnt;
    mem_write        = |gnt & sel.write;
    m0_waitrequest   = ~gnt[0];
    m1_waitrequest   = ~gnt[1];
    m0_readdatavalid = rd_pend & ~reset & ~rd_owner;
    m1_readdatavalid = rd_pend & ~reset & rd_owner;
    m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
  end
  // read+write together is served as a write, so only pure reads return data
  always_ff @(posedge clk)
    if (reset) begin
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
      proto_err <= 1'b0;
      rst_q     <= 1'b1;
    end else begin
      rd_pend   <= |gnt & sel.read & ~sel.write;
      rd_owner  <= win;
      proto_err <= proto_err | (m0_read & m0_write) | (m1_read & m1_write);
      rst_q     <= 1'b0;
    end
endmodule

// File: tb/tb_qsys_data_mem_arbiter.sv
// tb_qsys_data_mem_arbiter: directed checks of arbitration, read return, hold, reset and protocol error
module tb_qsys_data_mem_arbiter;
  logic clk = 0, reset = 1, hold = 0;
  logic [11:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, proto_err;
  int total = 0, bad = 0;
  logic [31:0] ram [4096];
  logic [11:0] aq = '0;

  qsys_data_mem_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // memory model: registered address, unregistered output, byte-enabled write
  always @(posedge clk)
    if (mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      aq <= mem_address;
    end
  assign mem_readdata = ram[aq];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input int n, input logic rd, input logic wr, input logic [11:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic idle;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    idle;
    nxt; nxt;
    @(negedge clk);
    chk("rst_w0", m0_waitrequest, 1);
    chk("rst_w1", m1_waitrequest, 1);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rd0", m0_readdata, 0);
    chk("rst_perr", proto_err, 0);
    nxt;
    reset = 0;
    drv(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("post_rst_cs", mem_chipselect, 0);
    chk("post_rst_w0", m0_waitrequest, 1);
    nxt;
    @(negedge clk);
    chk("wr_w0", m0_waitrequest, 0);
    chk("wr_cs", mem_chipselect, 1);
    chk("wr_mw", mem_write, 1);
    chk("wr_addr", mem_address, 12'h010);
    chk("wr_data", mem_writedata, 32'hDEADBEEF);
    nxt;
    drv(0, 1, 0, 12'h010, 4'hF, 0);
    @(negedge clk);
    chk("rd_w0", m0_waitrequest, 0);
    chk("rd_mw", mem_write, 0);
    chk("rd_w1", m1_waitrequest, 1);
    chk("rd_rdv0_early", m0_readdatavalid, 0);
    nxt;
    idle;
    @(negedge clk);
    chk("ret_rdv0", m0_readdatavalid, 1);
    chk("ret_rd0", m0_readdata, 32'hDEADBEEF);
    chk("ret_rdv1", m1_readdatavalid, 0);
    chk("ret_rd1", m1_readdata, 0);
    nxt;
    // prefill 0x100 / 0x200; last grant is m0, so m1 wins the tie
    drv(0, 0, 1, 12'h100, 4'hF, 32'h11110100);
    drv(1, 0, 1, 12'h200, 4'hF, 32'h22220200);
    @(negedge clk);
    chk("pf_w1", m1_waitrequest, 0);
    nxt;
    drv(1, 0, 0, 0, 0, 0);
    nxt;
    idle;
    drv(0, 1, 0, 12'h100, 4'hF, 0);
    drv(1, 1, 0, 12'h200, 4'hF, 0);
    for (int i = 0; i < 8; i++) begin
      w = (i % 2 == 0) ? 1 : 0;
      @(negedge clk);
      chk($sformatf("rr%0d_w0", i), m0_waitrequest, w == 1);
      chk($sformatf("rr%0d_w1", i), m1_waitrequest, w == 0);
      if (i > 0) begin
        chk($sformatf("rr%0d_rdv0", i), m0_readdatavalid, w == 1);
        chk($sformatf("rr%0d_rdv1", i), m1_readdatavalid, w == 0);
        chk($sformatf("rr%0d_rd", i), w == 1 ? m0_readdata : m1_readdata,
            w == 1 ? 32'h11110100 : 32'h22220200);
      end
      nxt;
    end
    idle;
    @(negedge clk);
    chk("rr_last_rdv0", m0_readdatavalid, 1);
    chk("rr_last_rd0", m0_readdata, 32'h11110100);
    chk("rr_last_rdv1", m1_readdatavalid, 0);
    nxt;
    drv(1, 0, 1, 12'h020, 4'hF, 32'h12345678);
    nxt;
    drv(1, 0, 1, 12'h020, 4'h3, 32'h0000AAAA);
    nxt;
    idle;
    drv(0, 1, 0, 12'h020, 4'hF, 0);
    nxt;
    idle;
    @(negedge clk);
    chk("be_rd0", m0_readdata, 32'h1234AAAA);
    nxt;
    // hold: m1 wins the cycle before hold (last grant m0), its read still returns
    drv(0, 1, 0, 12'h100, 4'hF, 0);
    drv(1, 1, 0, 12'h200, 4'hF, 0);
    @(negedge clk);
    chk("pre_hold_w1", m1_waitrequest, 0);
    nxt;
    hold = 1;
    @(negedge clk);
    chk("hold_rdv1", m1_readdatavalid, 1);
    chk("hold_rd1", m1_readdata, 32'h22220200);
    chk("hold_cs0", mem_chipselect, 0);
    chk("hold_w0", m0_waitrequest, 1);
    nxt;
    @(negedge clk);
    chk("hold_cs1", mem_chipselect, 0);
    nxt;
    @(negedge clk);
    chk("hold_cs2", mem_chipselect, 0);
    chk("hold_rdv1_end", m1_readdatavalid, 0);
    nxt;
    hold = 0;
    @(negedge clk);
    chk("unhold_w0", m0_waitrequest, 0);
    chk("unhold_w1", m1_waitrequest, 1);
    nxt;
    idle;
    nxt;
    // reset right after a read grant drops the return
    drv(0, 1, 0, 12'h100, 4'hF, 0);
    @(negedge clk);
    chk("prerst_w0", m0_waitrequest, 0);
    nxt;
    idle;
    reset = 1;
    @(negedge clk);
    chk("rst2_rdv0", m0_readdatavalid, 0);
    chk("rst2_rd0", m0_readdata, 0);
    chk("rst2_cs", mem_chipselect, 0);
    chk("rst2_w0", m0_waitrequest, 1);
    chk("rst2_w1", m1_waitrequest, 1);
    nxt;
    reset = 0;
    drv(0, 1, 0, 12'h100, 4'hF, 0);
    drv(1, 1, 0, 12'h200, 4'hF, 0);
    @(negedge clk);
    chk("rst2_post_cs", mem_chipselect, 0);
    chk("rst2_post_rdv0", m0_readdatavalid, 0);
    chk("rst2_post_rdv1", m1_readdatavalid, 0);
    nxt;
    @(negedge clk);
    chk("tie_w0", m0_waitrequest, 0);
    chk("tie_w1", m1_waitrequest, 1);
    nxt;
    idle;
    nxt;
    drv(0, 1, 1, 12'h030, 4'hF, 32'h55);
    @(negedge clk);
    chk("rw_cs", mem_chipselect, 1);
    chk("rw_mw", mem_write, 1);
    chk("rw_w0", m0_waitrequest, 0);
    nxt;
    idle;
    @(negedge clk);
    chk("rw_perr", proto_err, 1);
    chk("rw_rdv0", m0_readdatavalid, 0);
    nxt;
    drv(0, 1, 0, 12'h030, 4'hF, 0);
    nxt;
    idle;
    @(negedge clk);
    chk("rw_rd0", m0_readdata, 32'h55);
    chk("rw_perr_sticky", proto_err, 1);
    nxt;
    reset = 1;
    nxt;
    reset = 0;
    @(negedge clk);
    chk("rw_perr_clr", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
